// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative signed/unsigned multiply and restoring divide unit
// Define MULT_DIV_ZERO_TRAP_EN to short-circuit divide-by-zero straight from PREP to DONE.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  state_t               state, state_n;
  logic [1:0]           op_r;
  logic [WIDTH-1:0]     a_reg, b_reg;
  logic                 neg_a, neg_b, b_zero;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;

  logic                 signed_op;
  logic [WIDTH-1:0]     mag_a, mag_b, addend, sub;
  logic [WIDTH:0]       sum, shifted;
  logic                 ge, neg_res;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge Clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = PREP;
`ifdef MULT_DIV_ZERO_TRAP_EN
      PREP: state_n = (op_r[1] && b_reg == '0) ? DONE : CALC;
`else
      PREP: state_n = CALC;
`endif
      CALC: if (cnt == CNT_W'(1)) state_n = FIX;
      FIX:  state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // op[0]=0 selects the signed variant of both multiply and divide
  assign signed_op = ~op_r[0];
  assign mag_a     = (signed_op && a_reg[WIDTH-1]) ? -a_reg : a_reg;
  assign mag_b     = (signed_op && b_reg[WIDTH-1]) ? -b_reg : b_reg;

  // multiply: acc = {partial upper, remaining multiplier bits}, shifted right each step
  assign addend = acc[0] ? b_reg : '0;
  assign sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};

  // divide: acc = {remainder, dividend bits becoming quotient}, shifted left each step
  assign shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign ge      = (shifted >= {1'b0, b_reg});
  assign sub     = shifted[WIDTH-1:0] - b_reg;

  assign neg_res  = neg_a ^ neg_b;
  assign prod_fix = neg_res ? -acc : acc;
  assign quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge Clk) begin
    if (!reset) begin
      op_r        <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      neg_a       <= 1'b0;
      neg_b       <= 1'b0;
      b_zero      <= 1'b0;
      cnt         <= '0;
      acc         <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_reg <= a;
          b_reg <= b;
          op_r  <= op;
        end
        PREP: begin
          b_reg  <= mag_b;
          neg_a  <= signed_op & a_reg[WIDTH-1];
          neg_b  <= signed_op & b_reg[WIDTH-1];
          b_zero <= (b_reg == '0);
          acc    <= {{WIDTH{1'b0}}, mag_a};
          cnt    <= CNT_W'(WIDTH);
`ifdef MULT_DIV_ZERO_TRAP_EN
          if (op_r[1] && b_reg == '0) div_by_zero <= 1'b1;
`endif
        end
        CALC: begin
          cnt <= cnt - CNT_W'(1);
          if (op_r[1])
            acc <= ge ? {sub, acc[WIDTH-2:0], 1'b1}
                      : {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          else
            acc <= {sum, acc[WIDTH-1:1]};
        end
        FIX: begin
          if (op_r[1]) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else if (signed_op) begin
            {hi, lo} <= prod_fix;
          end else begin
            {hi, lo} <= acc;
          end
          div_by_zero <= op_r[1] & b_zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed and random checks of mult_div_unit against an arithmetic model
module tb_mult_div_unit;

  logic        Clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;

  mult_div_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                       output logic [31:0] eh, output logic [31:0] el,
                       output logic edbz, output int ecyc);
    longint sa, sb, p;
    logic [63:0] up;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    edbz = 1'b0;
    ecyc = 35;
    eh = '0;
    el = '0;
    case (mop)
      2'd0: begin p = sa * sb; {eh, el} = p; end
      2'd1: begin up = {32'b0, ma} * {32'b0, mb}; {eh, el} = up; end
      default: begin
        if (mb == 32'd0) begin
          edbz = 1'b1;
`ifdef MULT_DIV_ZERO_TRAP_EN
          eh = prev_hi;
          el = prev_lo;
          ecyc = 2;
`else
          eh = ma;
          el = (mop == 2'd2 && ma[31]) ? 32'h1 : 32'hFFFF_FFFF;
`endif
        end else if (mop == 2'd2) begin
          el = 32'(sa / sb);
          eh = 32'(sa % sb);
        end else begin
          el = ma / mb;
          eh = ma % mb;
        end
      end
    endcase
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     input bit poke, input string tag);
    logic [31:0] eh, el;
    logic edbz;
    int ecyc, n;
    model(o, x, y, eh, el, edbz, ecyc);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
    check({tag, " busy"}, busy, 1);
    n = 1;
    while (!done && n < 200) begin
      if (poke && n == 4) start = 1'b1;
      if (poke && n == 8) start = 1'b0;
      @(posedge Clk); #1;
      n++;
    end
    check({tag, " cycles"}, n, ecyc);
    check({tag, " hi"}, hi, eh);
    check({tag, " lo"}, lo, el);
    check({tag, " dbz"}, div_by_zero, edbz);
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    check({tag, " done pulse"}, done, 0);
    check({tag, " start in DONE ignored"}, busy, 0);
    check({tag, " hold"}, {hi, lo}, {eh, el});
    prev_hi = eh;
    prev_lo = el;
  endtask

  initial begin
    int seen;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    repeat (3) @(posedge Clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset dbz", div_by_zero, 0);
    reset = 1'b1;
    @(posedge Clk); #1;

    run(2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0, "mult neg");
    run(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "multu max");
    run(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, "div neg");
    run(2'd3, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, "divu");
    run(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div min/-1");
    run(2'd3, 32'h0000_0005, 32'h0000_0000, 1'b0, "divu by 0");

    // abort in the middle of CALC
    op = 2'd1; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge Clk); #1; end
    reset = 1'b0;
    @(posedge Clk); #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort hi", hi, 0);
    check("abort lo", lo, 0);
    check("abort dbz", div_by_zero, 0);
    reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge Clk); #1;
      if (done) seen++;
    end
    check("abort no done", seen, 0);
    prev_hi = '0;
    prev_lo = '0;
    run(2'd0, 32'h0000_0003, 32'hFFFF_FFFE, 1'b0, "after abort");
    run(2'd2, 32'hFFFF_FFF9, 32'h0000_0000, 1'b0, "div neg by 0");

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
      run(ro, ra, rb, bit'($urandom_range(0, 1)), $sformatf("rand%0d op%0d", i, ro));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
